// File: rtl/dmem_nic_responder_pkg.sv
// Shared definitions for the data-memory responder: NIC register offsets,
// STATUS field positions and sticky error bit indices.
package dmem_nic_responder_pkg;

   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_RXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_ERRCLR = 2'd3
   } nic_reg_e;

   localparam int STAT_RX_COUNT_SHIFT    = 16;
   localparam int STAT_TX_COUNT_SHIFT    = 8;
   localparam int STAT_RX_NONEMPTY_SHIFT = 1;
   localparam int STAT_TX_FULL_SHIFT     = 0;

   localparam int ERR_TX_OVERFLOW  = 0;
   localparam int ERR_RX_UNDERFLOW = 1;
   localparam int ERR_ADDR         = 2;
   localparam int ERR_BITS         = 3;

   function automatic logic [63:0] status_word(input logic [7:0] rx_count,
                                               input logic [7:0] tx_count,
                                               input logic       rx_nonempty,
                                               input logic       tx_full);
      return (64'(rx_count)    << STAT_RX_COUNT_SHIFT)
           | (64'(tx_count)    << STAT_TX_COUNT_SHIFT)
           | (64'(rx_nonempty) << STAT_RX_NONEMPTY_SHIFT)
           | (64'(tx_full)     << STAT_TX_FULL_SHIFT);
   endfunction

endpackage

// File: rtl/dmem_nic_responder_sync_fifo.sv
// Single-clock FIFO with a combinational head output (0 when empty).
// Push while full is legal only together with a pop of the same slot.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // NOTE: storage has no reset; the pointers and count alone define which
   // entries are live, so resetting the array would only cost flops.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   end

   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));
   assign count = r_count;
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dmem_nic_responder.sv
// Data-memory responder: local RAM plus a 4-word NIC window with TX/RX
// FIFOs toward the mesh router. Load data is returned in the request cycle.
module dmem_nic_responder
   import dmem_nic_responder_pkg::*;
#(
   parameter int          MEM_DEPTH  = 256,
   parameter logic [31:0] NIC_BASE   = 32'h0000_C000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_en,
   input  logic        mem_wr_en,
   input  logic [31:0] addr_in,
   input  logic [63:0] wr_data,
   output logic [63:0] rd_data,
   output logic [63:0] nic_tx_data,
   output logic        nic_tx_valid,
   input  logic        nic_tx_ready,
   input  logic [63:0] nic_rx_data,
   input  logic        nic_rx_valid,
   output logic        nic_rx_ready,
   output logic        err
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [63:0]         r_mem [MEM_DEPTH];
   logic [ERR_BITS-1:0] r_err;

   logic                w_load, w_store, w_is_ram, w_is_nic, w_unmapped;
   logic [31:0]         w_nic_off;
   nic_reg_e            w_reg;
   logic                w_sel_tx, w_sel_rx, w_sel_errclr;
   logic                w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic                w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   logic [CW-1:0]       w_tx_count, w_rx_count;
   logic [63:0]         w_rx_head, w_rd;
   logic [ERR_BITS-1:0] w_err_set;

   assign w_load     = mem_en & ~mem_wr_en;
   assign w_store    = mem_en & mem_wr_en;
   assign w_is_ram   = (addr_in < 32'(MEM_DEPTH));
   assign w_nic_off  = addr_in - NIC_BASE;
   assign w_is_nic   = ~w_is_ram & (w_nic_off < 32'd4);
   assign w_unmapped = ~w_is_ram & ~w_is_nic;
   assign w_reg      = nic_reg_e'(w_nic_off[1:0]);

   assign w_sel_tx     = w_is_nic & (w_reg == REG_TXDATA);
   assign w_sel_rx     = w_is_nic & (w_reg == REG_RXDATA);
   assign w_sel_errclr = w_is_nic & (w_reg == REG_ERRCLR);

   always_ff @(posedge clk) begin
      if (w_store && w_is_ram) r_mem[addr_in[AW-1:0]] <= wr_data;
   end

   // A full TX FIFO still accepts a store when the router drains the head that cycle.
   assign nic_tx_valid = ~w_tx_empty;
   assign w_tx_pop     = ~w_tx_empty & nic_tx_ready;
   assign w_tx_push    = w_store & w_sel_tx & (~w_tx_full | w_tx_pop);

   assign nic_rx_ready = ~w_rx_full;
   assign w_rx_push    = nic_rx_valid & ~w_rx_full;
   assign w_rx_pop     = w_load & w_sel_rx & ~w_rx_empty;

   sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_tx_push),
      .pop   (w_tx_pop),
      .din   (wr_data),
      .dout  (nic_tx_data),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .count (w_tx_count)
   );

   sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_rx_push),
      .pop   (w_rx_pop),
      .din   (nic_rx_data),
      .dout  (w_rx_head),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .count (w_rx_count)
   );

   always_comb begin
      w_err_set                   = '0;
      w_err_set[ERR_TX_OVERFLOW]  = w_store & w_sel_tx & w_tx_full & ~w_tx_pop;
      w_err_set[ERR_RX_UNDERFLOW] = w_load & w_sel_rx & w_rx_empty;
      w_err_set[ERR_ADDR]         = mem_en & w_unmapped;
   end

   // A clear and a new error in the same cycle leave the new bit set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_err <= '0;
      else        r_err <= ((w_store & w_sel_errclr) ? '0 : r_err) | w_err_set;
   end

   assign err = |r_err;

   // NOTE: w_rd gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_rd = '0;
      if (reset && w_load) begin
         if (w_is_ram) begin
            w_rd = r_mem[addr_in[AW-1:0]];
         end else if (w_is_nic) begin
            unique case (w_reg)
               REG_TXDATA: w_rd = '0;
               REG_RXDATA: w_rd = w_rx_head;
               REG_STATUS: w_rd = status_word(8'(w_rx_count), 8'(w_tx_count),
                                              ~w_rx_empty, w_tx_full);
               REG_ERRCLR: w_rd = 64'(r_err);
            endcase
         end
      end
   end

   assign rd_data = w_rd;

endmodule

// File: doc/dmem_nic_responder.md
Name: dmem_nic_responder

Overview:
Responder side of the processor's data-memory interface. It services load and store requests issued by the four-stage core (mem_en, mem_wr_en, addr, write data) and returns read data in the same cycle. It holds a local data RAM plus a memory-mapped network interface window, with a TX FIFO toward the mesh router and an RX FIFO from it. It sits between the core and the router's local port.

Parameters:
MEM_DEPTH, 256, number of 64-bit data RAM words; word index = addr_in, valid when addr_in < MEM_DEPTH
NIC_BASE, 32'h0000_C000, base word address of the NIC register window (4 words)
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, minimum 2

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
mem_en  in  1  request valid for this cycle
mem_wr_en  in  1  1 = store, 0 = load; ignored when mem_en = 0
addr_in  in  32  word address
wr_data  in  64  store data
rd_data  out  64  load data, combinational, valid in the request cycle
nic_tx_data  out  64  flit to router
nic_tx_valid  out  1  TX FIFO non-empty
nic_tx_ready  in  1  router accepts the flit
nic_rx_data  in  64  flit from router
nic_rx_valid  in  1  router presents a flit
nic_rx_ready  out  1  RX FIFO not full
err  out  1  OR of sticky error bits

Behaviour:
- Reset (reset = 0, asynchronous): FIFO pointers and counts = 0; error bits = 0; nic_tx_valid = 0; nic_tx_data = 0; nic_rx_ready = 1; rd_data = 0; err = 0. RAM contents are not reset.
- rd_data is 0 unless mem_en = 1 and mem_wr_en = 0. It is computed from the state present before the clock edge. There is no same-cycle write bypass.
- Address decode:
  - addr_in < MEM_DEPTH: RAM.
  - NIC_BASE+0: TXDATA.
  - NIC_BASE+1: RXDATA.
  - NIC_BASE+2: STATUS.
  - NIC_BASE+3: ERRCLR.
  - Anything else is unmapped.
- RAM:
  - Load returns mem[addr_in] combinationally.
  - Store writes wr_data at the rising edge.
- TXDATA:
  - Store pushes wr_data if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the data is dropped and tx_overflow is set.
  - Load returns 0 with no side effect.
- Router handshake:
  - nic_tx_data = head entry (0 when empty).
  - A pop occurs at the edge when nic_tx_valid and nic_tx_ready are both 1.
  - FIFO order is preserved.
- RXDATA load:
  - Non-empty: returns the head and pops it at the edge.
  - Empty: returns 0, no pop, sets rx_underflow.
  - Store to RXDATA is ignored.
- RX push: occurs when nic_rx_valid and nic_rx_ready are both 1. nic_rx_ready = !rx_full, so no push happens when full, even with a simultaneous pop. A push and a CPU pop in the same cycle on a non-empty FIFO are both performed.
- STATUS load value = (rx_count << 16) | (tx_count << 8) | (rx_nonempty << 1) | tx_full. Store to STATUS is ignored.
- ERRCLR:
  - Load returns {61'b0, addr_err, rx_underflow, tx_overflow} (bit 2 .. bit 0).
  - Store clears all three bits.
  - A new error in the same cycle as a clear wins, so the bit ends up set.
- Unmapped access: load returns 0 and sets addr_err; store is ignored and sets addr_err.
- Counts range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation: FIFOs are emptied immediately, and in-flight data is lost.

Decomposition:
- Shared package holds:
  - register offsets TXDATA = 0, RXDATA = 1, STATUS = 2, ERRCLR = 3;
  - STATUS field shifts (16, 8, 1, 0);
  - error bit indices.
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout (head), full, empty, count. It is instantiated twice, for TX and RX.

Test Plan:
- After reset: store 0xDEAD_BEEF to addr 5, then load addr 5 → rd_data = 0xDEAD_BEEF. Store to addr 5 and load addr 5 in the same cycle → load returns the old value.
- With nic_tx_ready = 0: store 0x11, 0x22, 0x33, 0x44, 0x55 to NIC_BASE+0 → STATUS = 0x0401, err = 1, ERRCLR reads 0x1. Then raise nic_tx_ready → router receives 0x11, 0x22, 0x33, 0x44 on four consecutive cycles, then nic_tx_valid = 0.
- Router pushes 0xA1, 0xA2 → STATUS = 0x20002. Loads of NIC_BASE+1 return 0xA1 then 0xA2, and STATUS = 0. A third load returns 0 and sets ERRCLR bit 1.
- Router pushes 4 flits → nic_rx_ready = 0 and the 5th flit is held. A CPU pop re-raises nic_rx_ready the next cycle, and the 5th flit is accepted. FIFO order is preserved.
- Load addr 0x1000 → rd_data = 0, ERRCLR = 0x4. A store to NIC_BASE+3 and a TX overflow in the same cycle → ERRCLR = 0x1.
- Assert reset with 3 TX entries pending → nic_tx_valid = 0 and STATUS = 0 immediately, without waiting for a clock edge.
